// File: rtl/instruction_sequencer.sv
// March-program store and sequencer feeding instruction_register: one word issued per element,
// next fetch only after the address generator reports the element done.
module instruction_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic          start,
    input  logic          abort,
    input  logic          elem_done,
    output logic          updwn_out,
    output logic [15:0]   op_out,
    output logic [3:0]    pol_out,
    output logic          no_out,
    output logic [7:0]    data_out,
    output logic          w_out,
    output logic [3:0]    admd_out,
    output logic          te_out,
    output logic          hold_out,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    state_t        state_q;
    logic [IW-1:0] mem_q [DEPTH];
    logic [AW-1:0] pc_q;
    logic [IW-1:0] fld_q;
    logic          hold_q;

    logic [IW-1:0] cur_word;
    logic          cur_op_zero;
    logic          cur_te;
    logic          at_last;
    logic          load_ok;

    assign cur_word    = mem_q[pc_q];
    assign cur_op_zero = (cur_word[34:19] == 16'h0000);
    assign cur_te      = cur_word[0];
    assign at_last     = (pc_q == PC_LAST);
    assign load_ok     = (state_q == S_IDLE) || (state_q == S_DONE);

    // Program store survives reset so a program can be rerun after a reset.
    always_ff @(posedge clk) begin
        if (ld_en && load_ok) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            fld_q   <= '0;
            hold_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !ld_en) begin
                        pc_q    <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        hold_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (cur_op_zero && !cur_te) begin
                        if (at_last) begin
                            state_q <= S_DONE;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end else if (cur_op_zero) begin
                        state_q <= S_DONE;
                    end else begin
                        fld_q   <= cur_word;
                        hold_q  <= 1'b0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    hold_q  <= 1'b1;
                    state_q <= abort ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    // abort outranks a coincident elem_done
                    if (abort) begin
                        hold_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (elem_done) begin
                        if (fld_q[0] || at_last) begin
                            state_q <= S_DONE;
                        end else begin
                            pc_q    <= pc_q + AW'(1);
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    hold_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign updwn_out = fld_q[35];
    assign op_out    = fld_q[34:19];
    assign pol_out   = fld_q[18:15];
    assign no_out    = fld_q[14];
    assign data_out  = fld_q[13:6];
    assign w_out     = fld_q[5];
    assign admd_out  = fld_q[4:1];
    assign te_out    = fld_q[0];
    assign hold_out  = hold_q;
    assign pc_out    = pc_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: drives and samples on the falling clock edge.
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst, ld_en, start, abort, elem_done;
    logic [3:0]  ld_addr;
    logic [35:0] ld_data;
    logic        updwn_out, no_out, w_out, te_out, hold_out, busy, done;
    logic [15:0] op_out;
    logic [3:0]  pol_out, admd_out, pc_out;
    logic [7:0]  data_out;
    logic [35:0] out_word;

    int total = 0;
    int bad   = 0;

    logic [35:0] iss [32];
    int n_iss, first_iss, ed_cyc, done_cyc, hold_bad, stab_bad;

    always #5 clk = ~clk;

    instruction_sequencer #(.DEPTH(16), .AW(4), .IW(36)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .abort(abort), .elem_done(elem_done),
        .updwn_out(updwn_out), .op_out(op_out), .pol_out(pol_out), .no_out(no_out),
        .data_out(data_out), .w_out(w_out), .admd_out(admd_out), .te_out(te_out),
        .hold_out(hold_out), .pc_out(pc_out), .busy(busy), .done(done)
    );

    assign out_word = {updwn_out, op_out, pol_out, no_out, data_out, w_out, admd_out, te_out};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic ud, input logic [15:0] op, input logic [3:0] pol,
                                       input logic no, input logic [7:0] dat, input logic w,
                                       input logic [3:0] admd, input logic te);
        return {ud, op, pol, no, dat, w, admd, te};
    endfunction

    function automatic logic [35:0] wordi(input int i);
        logic [31:0] v;
        v = i;
        return mk(v[0], 16'h0100 + v[15:0], v[3:0], v[1], v[7:0] * 8'd3, v[2], 4'd15 - v[3:0], 1'b0);
    endfunction

    task automatic load(input logic [3:0] a, input logic [35:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_hold_low();
        int n = 0;
        while (hold_out !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_low_seen", hold_out, 0);
    endtask

    // Pulses start, answers each issue with elem_done in the 5th WAIT cycle, stops at done.
    task automatic run(input int budget);
        int  cyc, wcnt;
        logic in_wait, prev_low;
        n_iss = 0; first_iss = -1; ed_cyc = -1; hold_bad = 0; stab_bad = 0;
        in_wait = 1'b0; prev_low = 1'b0; wcnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            elem_done = 1'b0;
            if (in_wait) begin
                wcnt++;
                if (wcnt == 5) begin
                    if (out_word !== iss[n_iss-1]) stab_bad++;
                    elem_done = 1'b1;
                    ed_cyc = cyc;
                    in_wait = 1'b0;
                end
            end
            if (hold_out === 1'b0) begin
                if (prev_low) hold_bad++;
                if (n_iss < 32) iss[n_iss] = out_word;
                if (first_iss < 0) first_iss = cyc;
                n_iss++;
                in_wait = 1'b1;
                wcnt = 0;
            end
            prev_low = (hold_out === 1'b0);
            @(negedge clk);
            cyc++;
        end
        elem_done = 1'b0;
        done_cyc = cyc;
        chk("run_reached_done", done, 1);
        chk("done_after_last_elem", done_cyc, ed_cyc + 1);
        chk("hold_single_cycle", hold_bad, 0);
        chk("fields_stable_in_wait", stab_bad, 0);
        chk("busy_clear_at_done", busy, 0);
        chk("hold_high_at_done", hold_out, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] w0, w1, w2, w0b;
        rst = 1'b1; ld_en = 1'b0; start = 1'b0; abort = 1'b0; elem_done = 1'b0;
        ld_addr = '0; ld_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_fields", out_word, 0);
        chk("rst_hold", hold_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc_out, 0);

        // Three-word program ending on te
        w0 = mk(1'b1, 16'h1234, 4'hA, 1'b1, 8'h55, 1'b1, 4'h3, 1'b0);
        w1 = mk(1'b0, 16'h00F0, 4'h5, 1'b0, 8'hAA, 1'b0, 4'hC, 1'b0);
        w2 = mk(1'b1, 16'hBEEF, 4'h1, 1'b1, 8'h0F, 1'b1, 4'h7, 1'b1);
        load(4'd0, w0);
        load(4'd1, w1);
        load(4'd2, w2);
        run(200);
        chk("p3_issue_count", n_iss, 3);
        chk("p3_first_issue_cycle", first_iss, 2);
        chk("p3_word0", iss[0], w0);
        chk("p3_word1", iss[1], w1);
        chk("p3_word2", iss[2], w2);
        chk("p3_pc_end", pc_out, 2);
        chk("p3_fields_kept", out_word, w2);

        // Leading NOP delays the first issue by one cycle
        load(4'd0, 36'h0);
        load(4'd1, mk(1'b0, 16'h0005, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1));
        run(200);
        chk("nop_issue_count", n_iss, 1);
        chk("nop_first_issue_cycle", first_iss, 3);
        chk("nop_word", iss[0], mk(1'b0, 16'h0005, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1));
        chk("nop_pc_end", pc_out, 1);

        // Full 16-word program without te
        for (int i = 0; i < 16; i++) load(4'(i), wordi(i));
        run(400);
        chk("full_issue_count", n_iss, 16);
        chk("full_word0", iss[0], wordi(0));
        chk("full_word15", iss[15], wordi(15));
        chk("full_pc_end", pc_out, 15);
        repeat (3) @(negedge clk);
        chk("full_no_wrap_pc", pc_out, 15);
        chk("full_done_held", done, 1);
        chk("full_hold_held", hold_out, 1);

        // Abort coincident with elem_done in WAIT of the second element
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_hold_low();
        @(negedge clk);
        elem_done = 1'b1;
        @(negedge clk);
        elem_done = 1'b0;
        wait_hold_low();
        chk("abort_pre_pc", pc_out, 1);
        @(negedge clk);
        abort = 1'b1; elem_done = 1'b1;
        @(negedge clk);
        abort = 1'b0; elem_done = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hold", hold_out, 1);
        chk("abort_pc_kept", pc_out, 1);

        // Writes while busy must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 36'h0;
        @(negedge clk);
        @(negedge clk);
        ld_en = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort2_busy", busy, 0);

        // start together with ld_en: write happens, start ignored
        w0b = mk(1'b0, 16'hCAFE, 4'h9, 1'b1, 8'h3C, 1'b1, 4'h2, 1'b0);
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = w0b; start = 1'b1;
        @(negedge clk);
        ld_en = 1'b0; start = 1'b0;
        chk("start_with_ld_ignored", busy, 0);

        // Reset during ISSUE, then rerun with program intact
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_hold_low();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_fields", out_word, 0);
        chk("midrst_hold", hold_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pc", pc_out, 0);
        run(400);
        chk("rerun_issue_count", n_iss, 16);
        chk("rerun_word0", iss[0], w0b);
        chk("rerun_word3_unchanged", iss[3], wordi(3));
        chk("rerun_word15", iss[15], wordi(15));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program store and sequencer that sits directly upstream of `instruction_register` in the PMBIST controller. It holds a small loadable march program, steps through it one march element at a time, and drives the instruction fields plus the `hold_in` strobe of `instruction_register`. It advances only when the address generator reports the current element complete. It also flags end-of-test.

## Interface
- `DEPTH`, 16: program words; power of two, ≥2.
- `AW`, 4: program address width, log2(DEPTH).
- `IW`, 36: instruction word width.
- Word layout: [35] updwn, [34:19] op, [18:15] pol, [14] no, [13:6] data, [5] w, [4:1] admd, [0] te.

- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ld_en` in 1: program-store write strobe.
- `ld_addr` in AW: write address.
- `ld_data` in IW: write data.
- `start` in 1: begin program execution at address 0.
- `abort` in 1: stop execution immediately.
- `elem_done` in 1: address generator has finished the current element.
- `updwn_out` out 1: field to `instruction_register`.
- `op_out` out 16: field to `instruction_register`.
- `pol_out` out 4: field to `instruction_register`.
- `no_out` out 1: field to `instruction_register`.
- `data_out` out 8: field to `instruction_register`.
- `w_out` out 1: field to `instruction_register`.
- `admd_out` out 4: field to `instruction_register`.
- `te_out` out 1: field to `instruction_register`.
- `hold_out` out 1: drives `instruction_register.hold_in`; low means capture.
- `pc_out` out AW: current program counter.
- `busy` out 1: program executing.
- `done` out 1: program completed; level signal.

## Operation
- Program store is a DEPTH×IW register array with combinational read.
  - It is not cleared by `rst`.
  - A write occurs when `ld_en`=1 and state is IDLE or DONE; `ld_en` is ignored otherwise.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE or DONE:
  - `start`=1 with `ld_en`=0: pc←0, `done`←0, go to FETCH.
  - `start` together with `ld_en`: the write occurs, `start` is ignored.
- FETCH: examine mem[pc].
  - op=0 and te=0 (NOP): not issued. If pc=DEPTH-1, go to DONE; else pc←pc+1 and stay in FETCH.
  - op=0 and te=1: go to DONE.
  - Otherwise: register all eight fields from the word, `hold_out`←0, go to ISSUE.
- ISSUE: lasts exactly one cycle. `hold_out`←1, go to WAIT.
- WAIT: fields are held stable.
  - On `elem_done`=1: if the word's te=1 or pc=DEPTH-1, go to DONE; else pc←pc+1 and go to FETCH.
  - `elem_done` is ignored in every state except WAIT.
- DONE: `done`=1, `busy`=0. Fields keep their last values and `hold_out`=1.
- `abort`=1 in FETCH, ISSUE or WAIT:
  - Next state IDLE, `hold_out`←1, `done` stays 0, pc is unchanged.
  - `abort` has priority over `elem_done`.
- `busy`=1 exactly in FETCH, ISSUE and WAIT.
- pc never wraps. Reaching DEPTH-1 always terminates the run.

## Timing
- Reset values: all field outputs 0, `hold_out`=1, pc=0, `busy`=0, `done`=0, state IDLE. `rst` mid-run returns to these values on the next edge.
- `start` sampled at edge k:
  - FETCH during cycle k+1.
  - Fields valid and `hold_out`=0 during cycle k+2 (no leading NOPs).
  - `instruction_register` captures at the end of cycle k+2.
  - WAIT from cycle k+3.
- Each leading or intervening NOP adds one FETCH cycle.
- `elem_done` sampled at edge j in WAIT: FETCH in j+1, next issue in j+2. Minimum element-to-element gap is 3 cycles.
- Fields change only on the FETCH→ISSUE edge. `hold_out` is low for exactly one cycle per issued word.
- `done` rises the cycle after the terminating `elem_done` or FETCH decision.

## Test plan
- Reset → all fields 0, `hold_out`=1, `busy`=0, `done`=0, pc=0.
- Load a 3-word program with te=1 on word 2; pulse `start`; `elem_done` 5 cycles into each WAIT:
  - exactly 3 single-cycle `hold_out` lows,
  - fields match each word,
  - `done`=1 after the third `elem_done`, `busy`=0.
- Program with word0=NOP, word1 op=16'h0005, te=1: first issue one cycle later than normal (cycle k+3); `done` after one element.
- No te anywhere, all words non-NOP: 16 elements issued, `done` after the `elem_done` at pc=15, no wrap to pc=0.
- `abort` asserted in WAIT in the same cycle as `elem_done`: IDLE, pc unchanged, `done`=0, `hold_out`=1. `ld_en` during `busy` leaves memory unchanged (read back via a rerun).
- `rst` asserted in ISSUE: next cycle shows reset values. A subsequent `start` reruns from pc=0 with the program intact.
